// File: rtl/lmac_reg_pkg.sv
// Shared definitions for the LMAC register responder: register map, FSM encoding, and address helpers.
package lmac_reg_pkg;

  localparam logic [15:0] REG_ID      = 16'h0000;
  localparam logic [15:0] REG_CFG     = 16'h0004;
  localparam logic [15:0] REG_SCRATCH = 16'h0008;
  localparam logic [15:0] REG_STATUS  = 16'h000C;
  localparam logic [15:0] REG_TXCNT   = 16'h0010;
  localparam logic [15:0] REG_RXCNT   = 16'h0014;

  localparam logic [31:0] UNMAPPED_RDATA = 32'h0000_0000;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_RD_WAIT = 4'b0010,
    ST_RD_DONE = 4'b0100,
    ST_WR_DONE = 4'b1000
  } state_t;

  // Byte lanes are ignored: every access targets the enclosing 32-bit word.
  function automatic logic [15:0] word_addr(input logic [15:0] a);
    return {a[15:2], 2'b00};
  endfunction

  function automatic logic is_mapped(input logic [15:0] a);
    return word_addr(a) inside {REG_ID, REG_CFG, REG_SCRATCH, REG_STATUS, REG_TXCNT, REG_RXCNT};
  endfunction

endpackage

// File: rtl/lmac_reg_responder_if.sv
// Host register-access bus between the AXIS-master read initiator (master) and the LMAC responder (slave).
interface lmac_reg_responder_if;
  // Handshake: the master pulses reg_rd_start or reg_wr_start for exactly one cycle with host_addr
  // (and reg_wdata for writes) valid in that cycle. The slave answers with a one-cycle done pulse;
  // mac_regdout is valid from the read done onward and reg_err qualifies either done. Starts that
  // arrive while the slave is busy are dropped and never answered.
  logic [15:0] host_addr;
  logic        reg_rd_start;
  logic        reg_wr_start;
  logic [31:0] reg_wdata;
  logic [31:0] mac_regdout;
  logic        reg_rd_done_out;
  logic        reg_wr_done_out;
  logic        reg_err;

  modport master (
    output host_addr, reg_rd_start, reg_wr_start, reg_wdata,
    input  mac_regdout, reg_rd_done_out, reg_wr_done_out, reg_err
  );

  modport slave (
    input  host_addr, reg_rd_start, reg_wr_start, reg_wdata,
    output mac_regdout, reg_rd_done_out, reg_wr_done_out, reg_err
  );
endinterface

// File: rtl/lmac_reg_sat_cnt.sv
// 32-bit event counter that sticks at all-ones; clr wins over the old value, then inc is applied.
module lmac_reg_sat_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        clr,
  output logic [31:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= {31'd0, inc};
    end else if (inc && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/lmac_reg_responder.sv
// LMAC control/status register bank answering host reads after RD_LATENCY cycles and writes after one.
// Build option: define LMAC_REG_CLR_ON_READ_EN to clear the packet counters on a completed read.
module lmac_reg_responder
  import lmac_reg_pkg::*;
#(
  parameter int          RD_LATENCY = 3,
  parameter logic [31:0] ID_VALUE   = 32'h4C4D_4132,
  parameter logic [31:0] CFG_RESET  = 32'h0000_0001
) (
  input  logic                 reg_clk,
  input  logic                 reset,
  lmac_reg_responder_if.slave  host,
  input  logic [31:0]          status_in,
  input  logic                 tx_pkt_pulse,
  input  logic                 rx_pkt_pulse,
  output logic [31:0]          cfg_out,
  output state_t               state_dbg
);

  // RD_WAIT lasts RD_LATENCY-1 cycles; its counter starts at 0 on entry.
  localparam logic [2:0] WAIT_LAST = (RD_LATENCY >= 2) ? 3'(RD_LATENCY - 2) : 3'd0;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q;
  logic [15:0] addr_q;
  logic [31:0] dout_q;
  logic        err_q;
  logic [31:0] cfg_q;
  logic [31:0] scratch_q;
  logic [31:0] tx_cnt, rx_cnt;

  logic        rd_accept, wr_accept, rd_fire;
  logic [15:0] rd_addr;
  logic [31:0] rd_data;
  logic        tx_clr, rx_clr;

  assign rd_accept = (state_q == ST_IDLE) && host.reg_rd_start;
  assign wr_accept = (state_q == ST_IDLE) && !host.reg_rd_start && host.reg_wr_start;
  assign rd_fire   = (state_d == ST_RD_DONE);
  // With RD_LATENCY=1 the read completes on the accepting edge, before addr_q is loaded.
  assign rd_addr   = (state_q == ST_IDLE) ? host.host_addr : addr_q;

  always_ff @(posedge reg_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == ST_RD_WAIT) ? cnt_q + 3'd1 : 3'd0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (host.reg_rd_start) begin
          state_d = (RD_LATENCY == 1) ? ST_RD_DONE : ST_RD_WAIT;
        end else if (host.reg_wr_start) begin
          state_d = ST_WR_DONE;
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == WAIT_LAST) state_d = ST_RD_DONE;
      end
      ST_RD_DONE: state_d = ST_IDLE;
      ST_WR_DONE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    host.reg_rd_done_out = (state_q == ST_RD_DONE);
    host.reg_wr_done_out = (state_q == ST_WR_DONE);
    host.reg_err         = err_q && ((state_q == ST_RD_DONE) || (state_q == ST_WR_DONE));
    host.mac_regdout     = dout_q;
    cfg_out              = cfg_q;
    state_dbg            = state_q;
  end

  always_comb begin
    rd_data = UNMAPPED_RDATA;
    case (word_addr(rd_addr))
      REG_ID:      rd_data = ID_VALUE;
      REG_CFG:     rd_data = cfg_q;
      REG_SCRATCH: rd_data = scratch_q;
      REG_STATUS:  rd_data = status_in;
      REG_TXCNT:   rd_data = tx_cnt;
      REG_RXCNT:   rd_data = rx_cnt;
      default:     rd_data = UNMAPPED_RDATA;
    endcase
  end

  // Read data, error flag and register updates all land on the edge entering the done state.
  always_ff @(posedge reg_clk or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      dout_q    <= '0;
      err_q     <= 1'b0;
      cfg_q     <= CFG_RESET;
      scratch_q <= '0;
    end else begin
      if (rd_accept) addr_q <= host.host_addr;
      if (rd_fire) begin
        dout_q <= rd_data;
        err_q  <= !is_mapped(rd_addr);
      end else if (wr_accept) begin
        err_q <= !is_mapped(host.host_addr);
        if (word_addr(host.host_addr) == REG_CFG)     cfg_q     <= host.reg_wdata;
        if (word_addr(host.host_addr) == REG_SCRATCH) scratch_q <= host.reg_wdata;
      end
    end
  end

`ifdef LMAC_REG_CLR_ON_READ_EN
  assign tx_clr = rd_fire && (word_addr(rd_addr) == REG_TXCNT);
  assign rx_clr = rd_fire && (word_addr(rd_addr) == REG_RXCNT);
`else
  assign tx_clr = 1'b0;
  assign rx_clr = 1'b0;
`endif

  lmac_reg_sat_cnt u_tx_cnt (
    .clk   (reg_clk),
    .rst   (reset),
    .inc   (tx_pkt_pulse),
    .clr   (tx_clr),
    .count (tx_cnt)
  );

  lmac_reg_sat_cnt u_rx_cnt (
    .clk   (reg_clk),
    .rst   (reset),
    .inc   (rx_pkt_pulse),
    .clr   (rx_clr),
    .count (rx_cnt)
  );

endmodule

// File: tb/tb_lmac_reg_responder.sv
// Directed and randomized bench for lmac_reg_responder against a cycle-level register-map model.
module tb_lmac_reg_responder;
  import lmac_reg_pkg::*;

  localparam int          RD_LATENCY = 3;
  localparam logic [31:0] ID_VALUE   = 32'h4C4D_4132;
  localparam logic [31:0] CFG_RESET  = 32'h0000_0001;

  // clock / reset
  logic        reg_clk = 1'b0;
  logic        reset;
  logic [31:0] status_in;
  logic        tx_pkt_pulse, rx_pkt_pulse;
  logic [31:0] cfg_out;
  state_t      state_dbg;

  lmac_reg_responder_if host_if ();

  always #5 reg_clk = ~reg_clk;

  lmac_reg_responder #(
    .RD_LATENCY (RD_LATENCY),
    .ID_VALUE   (ID_VALUE),
    .CFG_RESET  (CFG_RESET)
  ) dut (
    .reg_clk      (reg_clk),
    .reset        (reset),
    .host         (host_if),
    .status_in    (status_in),
    .tx_pkt_pulse (tx_pkt_pulse),
    .rx_pkt_pulse (rx_pkt_pulse),
    .cfg_out      (cfg_out),
    .state_dbg    (state_dbg)
  );

  // reference model state
  logic [31:0] m_cfg, m_scratch, m_tx, m_rx, m_dout;
  logic [15:0] m_addr;
  int          m_wait;
  bit          m_in_done;
  bit          exp_rd_done, exp_wr_done, exp_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_rd_done_seen = 0;
  bit rand_pulses = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_mapped(input logic [15:0] a);
    return int'(a[15:2]) <= 5;
  endfunction

  function automatic logic [31:0] m_read(input logic [15:0] a);
    case (int'(a[15:2]))
      0:       return ID_VALUE;
      1:       return m_cfg;
      2:       return m_scratch;
      3:       return status_in;
      4:       return m_tx;
      5:       return m_rx;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] v, input logic p);
    return (p && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  task automatic model_reset();
    m_cfg = CFG_RESET; m_scratch = 0; m_tx = 0; m_rx = 0; m_dout = 0; m_addr = 0;
    m_wait = 0; m_in_done = 0;
    exp_rd_done = 0; exp_wr_done = 0; exp_err = 0;
  endtask

  // Called just after each rising edge, using the inputs that were stable at that edge.
  task automatic model_edge();
    bit idle, next_in_done, clr_tx, clr_rx;
    if (reset) begin
      model_reset();
      return;
    end
    exp_rd_done = 0; exp_wr_done = 0; exp_err = 0;
    next_in_done = 0; clr_tx = 0; clr_rx = 0;
    idle = (m_wait == 0) && !m_in_done;
    if (idle && host_if.reg_rd_start) begin
      m_addr = host_if.host_addr;
      m_wait = RD_LATENCY;
    end else if (idle && host_if.reg_wr_start) begin
      case (int'(host_if.host_addr[15:2]))
        1: m_cfg = host_if.reg_wdata;
        2: m_scratch = host_if.reg_wdata;
        default: ;
      endcase
      exp_wr_done = 1; exp_err = !m_mapped(host_if.host_addr); next_in_done = 1;
    end
    if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_dout = m_read(m_addr);
        exp_rd_done = 1; exp_err = !m_mapped(m_addr); next_in_done = 1;
`ifdef LMAC_REG_CLR_ON_READ_EN
        clr_tx = (int'(m_addr[15:2]) == 4);
        clr_rx = (int'(m_addr[15:2]) == 5);
`endif
      end
    end
    m_tx = sat_add(clr_tx ? 32'h0 : m_tx, tx_pkt_pulse);
    m_rx = sat_add(clr_rx ? 32'h0 : m_rx, rx_pkt_pulse);
    m_in_done = next_in_done;
  endtask

  task automatic check_outputs();
    chk("rd_done", 32'(host_if.reg_rd_done_out), 32'(exp_rd_done));
    chk("wr_done", 32'(host_if.reg_wr_done_out), 32'(exp_wr_done));
    chk("reg_err", 32'(host_if.reg_err), 32'(exp_err));
    chk("mac_regdout", host_if.mac_regdout, m_dout);
    chk("cfg_out", cfg_out, m_cfg);
    if (host_if.reg_rd_done_out) n_rd_done_seen++;
  endtask

  task automatic tick();
    @(posedge reg_clk);
    model_edge();
    #1;
    cyc++;
    check_outputs();
    status_in = $urandom;
    tx_pkt_pulse = rand_pulses ? 1'($urandom_range(0, 1)) : 1'b0;
    rx_pkt_pulse = rand_pulses ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  // driver tasks
  task automatic do_read(input logic [15:0] addr, input bit pulse_on_done, input bit poke_busy,
                         output logic [31:0] data, output logic err, output int lat);
    int start_cyc;
    start_cyc = cyc;
    host_if.host_addr = addr;
    host_if.reg_rd_start = 1'b1;
    if (pulse_on_done && RD_LATENCY == 1) tx_pkt_pulse = 1'b1;
    tick();
    host_if.reg_rd_start = 1'b0;
    for (int k = 1; k < RD_LATENCY; k++) begin
      if (poke_busy && k == 1) begin
        host_if.reg_rd_start = 1'b1;
        host_if.host_addr = 16'h0004;
      end
      if (pulse_on_done && k == RD_LATENCY - 1) tx_pkt_pulse = 1'b1;
      tick();
      host_if.reg_rd_start = 1'b0;
    end
    chk("rd_done_at_latency", 32'(host_if.reg_rd_done_out), 32'd1);
    data = host_if.mac_regdout;
    err = host_if.reg_err;
    lat = cyc - start_cyc;
    tick();
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [31:0] data);
    host_if.host_addr = addr;
    host_if.reg_wdata = data;
    host_if.reg_wr_start = 1'b1;
    tick();
    host_if.reg_wr_start = 1'b0;
    chk("wr_done_next_cycle", 32'(host_if.reg_wr_done_out), 32'd1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rdata;
    logic        rerr;
    int          lat, done_before, start_cyc;

    reset = 1'b1;
    status_in = 0; tx_pkt_pulse = 0; rx_pkt_pulse = 0;
    host_if.host_addr = 0; host_if.reg_rd_start = 0; host_if.reg_wr_start = 0; host_if.reg_wdata = 0;
    model_reset();
    repeat (3) tick();
    chk("reset_dout", host_if.mac_regdout, 32'h0);
    chk("reset_cfg", cfg_out, CFG_RESET);
    #3 reset = 1'b0;
    cyc = 0;
    while (cyc < 10) tick();

    // ID read started in cycle 10 completes in cycle 13
    start_cyc = cyc;
    do_read(16'h0000, 0, 0, rdata, rerr, lat);
    chk("id_start_cycle", 32'(start_cyc), 32'd10);
    chk("id_latency", 32'(lat), 32'(RD_LATENCY));
    chk("id_data", rdata, ID_VALUE);
    chk("id_err", 32'(rerr), 32'd0);
    repeat (2) tick();
    chk("id_data_hold", host_if.mac_regdout, ID_VALUE);

    // scratch round trip; write to read-only ID is dropped without error
    do_write(16'h0008, 32'hA5A5_1234);
    do_read(16'h0008, 0, 0, rdata, rerr, lat);
    chk("scratch_rb", rdata, 32'hA5A5_1234);
    do_write(16'h0000, 32'hDEAD_BEEF);
    do_read(16'h0003, 0, 0, rdata, rerr, lat);
    chk("id_after_wr", rdata, ID_VALUE);

    // unmapped read, with a second start while busy
    done_before = n_rd_done_seen;
    do_read(16'h0040, 0, 1, rdata, rerr, lat);
    chk("unmapped_data", rdata, 32'h0);
    chk("unmapped_err", 32'(rerr), 32'd1);
    repeat (RD_LATENCY + 3) tick();
    chk("busy_start_dropped", 32'(n_rd_done_seen - done_before), 32'd1);

    // simultaneous read and write: the read wins
    done_before = n_rd_done_seen;
    host_if.host_addr = 16'h0004; host_if.reg_wdata = 32'hFF;
    host_if.reg_rd_start = 1'b1; host_if.reg_wr_start = 1'b1;
    tick();
    host_if.reg_rd_start = 1'b0; host_if.reg_wr_start = 1'b0;
    repeat (RD_LATENCY + 2) tick();
    chk("simul_cfg", cfg_out, 32'h1);
    chk("simul_one_done", 32'(n_rd_done_seen - done_before), 32'd1);

    // packet counter
    repeat (5) begin tx_pkt_pulse = 1'b1; tick(); end
    tick();
    do_read(16'h0010, 1, 0, rdata, rerr, lat);
    chk("txcnt_5", rdata, 32'd5);
    do_read(16'h0010, 0, 0, rdata, rerr, lat);
`ifdef LMAC_REG_CLR_ON_READ_EN
    chk("txcnt_after", rdata, 32'd1);
`else
    chk("txcnt_after", rdata, 32'd6);
`endif

    // randomized traffic, including starts while busy and unmapped addresses
    rand_pulses = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      host_if.reg_rd_start = ($urandom_range(0, 3) == 0);
      host_if.reg_wr_start = ($urandom_range(0, 3) == 0);
      host_if.host_addr = 16'($urandom_range(0, 9) * 4 + $urandom_range(0, 3));
      host_if.reg_wdata = $urandom;
      tick();
    end
    host_if.reg_rd_start = 1'b0; host_if.reg_wr_start = 1'b0;
    rand_pulses = 1'b0;
    repeat (RD_LATENCY + 2) tick();

    // reset in RD_WAIT aborts the read and clears outputs immediately
    do_write(16'h0004, 32'h0000_ABCD);
    do_read(16'h0000, 0, 0, rdata, rerr, lat);
    done_before = n_rd_done_seen;
    host_if.host_addr = 16'h0008; host_if.reg_rd_start = 1'b1;
    tick();
    host_if.reg_rd_start = 1'b0;
    #3 reset = 1'b1;
    #1;
    chk("async_rst_dout", host_if.mac_regdout, 32'h0);
    chk("async_rst_cfg", cfg_out, CFG_RESET);
    chk("async_rst_rd_done", 32'(host_if.reg_rd_done_out), 32'd0);
    chk("async_rst_err", 32'(host_if.reg_err), 32'd0);
    model_reset();
    repeat (2) tick();
    #3 reset = 1'b0;
    repeat (RD_LATENCY + 2) tick();
    chk("no_done_after_abort", 32'(n_rd_done_seen - done_before), 32'd0);
    do_read(16'h0008, 0, 0, rdata, rerr, lat);
    chk("scratch_after_rst", rdata, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
